ifu_fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined CPU. It holds the program counter and issues one instruction-memory request at a time with a req/ack handshake. It loads the fetched instruction into the IF/ID pipeline register and advances the PC to the `PC_next` value selected by the next-PC multiplexer. It sits directly downstream of that multiplexer: it consumes `PC_next` and supplies `IFU_PC_add_4` back to it.

---
 rtl/ifu_fetch_stage.sv | 141 ++++++++++++++
 tb/tb_ifu_fetch_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_stage.sv
// Instruction-fetch stage: owns the program counter, issues one instruction-memory
// request at a time over a req/ack handshake, and loads the IF/ID pipeline register.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   PC_next         next PC chosen by the upstream next-PC mux
//   redirect        one-cycle pulse, PC_next is a non-sequential target
//   stall           hazard unit freezes PC and IF/ID
//   imem_req/addr   fetch request and address (address stable until ack)
//   imem_ack/rdata  memory response, may coincide with the request
//   IFU_PC          current PC; IFU_PC_add_4 is IFU_PC + 4 (wraps)
//   IFID_*          IF/ID register: valid flag, instruction PC, instruction word

`ifndef IFU_DATAWIDTH
`define IFU_DATAWIDTH 32
`endif

module ifu_fetch_stage #(
  parameter int unsigned           DATAWIDTH = `IFU_DATAWIDTH,
  parameter logic [DATAWIDTH-1:0] RESET_PC  = 32'h8000_0000,
  parameter logic [31:0]          NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATAWIDTH-1:0] PC_next,
  input  logic                 redirect,
  input  logic                 stall,
  output logic                 imem_req,
  output logic [DATAWIDTH-1:0] imem_addr,
  input  logic                 imem_ack,
  input  logic [31:0]          imem_rdata,
  output logic [DATAWIDTH-1:0] IFU_PC,
  output logic [DATAWIDTH-1:0] IFU_PC_add_4,
  output logic                 IFID_valid,
  output logic [DATAWIDTH-1:0] IFID_PC,
  output logic [31:0]          IFID_instr
);

  typedef enum logic [1:0] {StFetch, StHold, StDrain} state_e;

  state_e                 state_q, state_d;
  logic [DATAWIDTH-1:0]   pc_q, pc_d;
  logic [DATAWIDTH-1:0]   req_addr_q, req_addr_d;
  logic [DATAWIDTH-1:0]   hold_pc_q, hold_pc_d;
  logic [31:0]            hold_instr_q, hold_instr_d;
  logic                   ifid_valid_q, ifid_valid_d;
  logic [DATAWIDTH-1:0]   ifid_pc_q, ifid_pc_d;
  logic [31:0]            ifid_instr_q, ifid_instr_d;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;

    case (state_q)
      StFetch: begin
        if (redirect) begin
          pc_d         = PC_next;
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
          // Without an ack the request is still in flight and must be drained.
          if (!imem_ack) state_d = StDrain;
        end else if (imem_ack && stall) begin
          hold_instr_d = imem_rdata;
          hold_pc_d    = pc_q;
          state_d      = StHold;
        end else if (imem_ack) begin
          ifid_valid_d = 1'b1;
          ifid_pc_d    = pc_q;
          ifid_instr_d = imem_rdata;
          pc_d         = PC_next;
        end else if (!stall) begin
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
        end
      end
      StHold: begin
        if (redirect) begin
          pc_d         = PC_next;
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
          state_d      = StFetch;
        end else if (!stall) begin
          ifid_valid_d = 1'b1;
          ifid_pc_d    = hold_pc_q;
          ifid_instr_d = hold_instr_q;
          pc_d         = PC_next;
          state_d      = StFetch;
        end
      end
      StDrain: begin
        ifid_valid_d = 1'b0;
        ifid_instr_d = NOP_INSTR;
        if (redirect) pc_d = PC_next;
        // The abandoned request completes here; a coincident redirect has
        // already updated the PC, so fetching can resume straight away.
        if (imem_ack) state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase

    // Keeping req_addr equal to the next PC makes imem_addr track IFU_PC in
    // FETCH without a combinational path from the PC mux.
    req_addr_d = (state_d == StDrain) ? req_addr_q : pc_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
    end
  end

  assign imem_req     = (state_q == StFetch || state_q == StDrain) && !rst;
  assign imem_addr    = req_addr_q;
  assign IFU_PC       = pc_q;
  assign IFU_PC_add_4 = pc_q + DATAWIDTH'(4);
  assign IFID_valid   = ifid_valid_q;
  assign IFID_PC      = ifid_pc_q;
  assign IFID_instr   = ifid_instr_q;

endmodule

// File: tb/tb_ifu_fetch_stage.sv
module tb_ifu_fetch_stage;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, redirect, stall, imem_ack;
  logic [31:0] tgt;
  logic [31:0] PC_next, imem_addr, imem_rdata, IFU_PC, IFU_PC_add_4, IFID_PC, IFID_instr;
  logic        imem_req, IFID_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Memory content is a fixed scramble of the address so stale words are detectable.
  function automatic logic [31:0] w(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = w(imem_addr);
  // Next-PC mux model: sequential unless redirecting.
  assign PC_next    = redirect ? tgt : IFU_PC_add_4;

  ifu_fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .PC_next      (PC_next),
    .redirect     (redirect),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .IFU_PC       (IFU_PC),
    .IFU_PC_add_4 (IFU_PC_add_4),
    .IFID_valid   (IFID_valid),
    .IFID_PC      (IFID_PC),
    .IFID_instr   (IFID_instr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed and checked away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; stall = 1'b0; imem_ack = 1'b1; tgt = '0;
    tick();
    tick();
    #1;
    chk("rst_req",        32'(imem_req),   32'd0);
    chk("rst_pc",         IFU_PC,          32'h8000_0000);
    chk("rst_addr",       imem_addr,       32'h8000_0000);
    chk("rst_valid",      32'(IFID_valid), 32'd0);
    chk("rst_ifid_pc",    IFID_PC,         32'h0);
    chk("rst_ifid_instr", IFID_instr,      Nop);

    // Sequential zero-wait fetch
    rst = 1'b0; #1;
    chk("seq_req0",  32'(imem_req), 32'd1);
    chk("seq_addr0", imem_addr,     32'h8000_0000);
    chk("seq_add4",  IFU_PC_add_4,  32'h8000_0004);
    tick(); #1;
    chk("seq_addr1",  imem_addr,       32'h8000_0004);
    chk("seq_valid1", 32'(IFID_valid), 32'd1);
    chk("seq_ifpc1",  IFID_PC,         32'h8000_0000);
    chk("seq_inst1",  IFID_instr,      w(32'h8000_0000));
    tick(); #1;
    chk("seq_addr2", imem_addr, 32'h8000_0008);
    chk("seq_ifpc2", IFID_PC,   32'h8000_0004);

    // Stall on ack at 8000_0008 for three cycles
    stall = 1'b1;
    tick(); #1;
    chk("hold_req_a",  32'(imem_req), 32'd0);
    chk("hold_ifpc_a", IFID_PC,       32'h8000_0004);
    chk("hold_pc_a",   IFU_PC,        32'h8000_0008);
    tick(); #1;
    chk("hold_req_b",  32'(imem_req), 32'd0);
    chk("hold_inst_b", IFID_instr,    w(32'h8000_0004));
    tick();
    stall = 1'b0; #1;
    chk("hold_req_c", 32'(imem_req), 32'd0);
    tick(); #1;
    chk("unhold_valid", 32'(IFID_valid), 32'd1);
    chk("unhold_ifpc",  IFID_PC,         32'h8000_0008);
    chk("unhold_inst",  IFID_instr,      w(32'h8000_0008));
    chk("unhold_req",   32'(imem_req),   32'd1);
    chk("unhold_addr",  imem_addr,       32'h8000_000C);

    // Redirect with zero-wait ack: acked word at 8000_000C is dropped
    redirect = 1'b1; tgt = 32'h8000_0100;
    tick();
    redirect = 1'b0; #1;
    chk("rdz_valid", 32'(IFID_valid), 32'd0);
    chk("rdz_inst",  IFID_instr,      Nop);
    chk("rdz_ifpc",  IFID_PC,         32'h8000_0008);
    chk("rdz_addr",  imem_addr,       32'h8000_0100);
    tick(); #1;
    chk("rdz_ifpc2", IFID_PC,    32'h8000_0100);
    chk("rdz_inst2", IFID_instr, w(32'h8000_0100));

    // Redirect during multi-cycle fetch of 8000_0104
    imem_ack = 1'b0;
    tick(); #1;
    chk("mc_bubble", 32'(IFID_valid), 32'd0);
    chk("mc_addr0",  imem_addr,       32'h8000_0104);
    redirect = 1'b1; tgt = 32'h8000_0200;
    tick();
    redirect = 1'b0; #1;
    chk("mc_req1",   32'(imem_req),   32'd1);
    chk("mc_addr1",  imem_addr,       32'h8000_0104);
    chk("mc_pc1",    IFU_PC,          32'h8000_0200);
    chk("mc_valid1", 32'(IFID_valid), 32'd0);
    tick();
    imem_ack = 1'b1; #1;
    chk("mc_addr2", imem_addr, 32'h8000_0104);
    tick(); #1;
    chk("mc_addr3",  imem_addr,       32'h8000_0200);
    chk("mc_valid3", 32'(IFID_valid), 32'd0);
    chk("mc_req3",   32'(imem_req),   32'd1);
    tick(); #1;
    chk("mc_valid4", 32'(IFID_valid), 32'd1);
    chk("mc_ifpc4",  IFID_PC,         32'h8000_0200);
    chk("mc_inst4",  IFID_instr,      w(32'h8000_0200));
    chk("mc_pc4",    IFU_PC,          32'h8000_0204);

    // Redirect and stall together while in HOLD
    stall = 1'b1;
    tick();
    redirect = 1'b1; tgt = 32'h8000_0300; #1;
    chk("rs_req", 32'(imem_req), 32'd0);
    tick();
    redirect = 1'b0; stall = 1'b0; #1;
    chk("rs_valid", 32'(IFID_valid), 32'd0);
    chk("rs_pc",    IFU_PC,          32'h8000_0300);
    chk("rs_addr",  imem_addr,       32'h8000_0300);
    tick(); #1;
    chk("rs_ifpc", IFID_PC,    32'h8000_0300);
    chk("rs_inst", IFID_instr, w(32'h8000_0300));

    // PC wrap
    redirect = 1'b1; tgt = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0; #1;
    chk("wrap_add4", IFU_PC_add_4, 32'h0);
    tick(); #1;
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_ifpc", IFID_PC,   32'hFFFF_FFFC);

    // Reset while a request is outstanding; late ack is ignored
    imem_ack = 1'b0; rst = 1'b1;
    tick();
    imem_ack = 1'b1; #1;
    chk("mr_req",   32'(imem_req),   32'd0);
    chk("mr_pc",    IFU_PC,          32'h8000_0000);
    chk("mr_addr",  imem_addr,       32'h8000_0000);
    chk("mr_valid", 32'(IFID_valid), 32'd0);
    chk("mr_ifpc",  IFID_PC,         32'h0);
    chk("mr_inst",  IFID_instr,      Nop);
    tick(); #1;
    chk("mr_valid2", 32'(IFID_valid), 32'd0);
    chk("mr_pc2",    IFU_PC,          32'h8000_0000);
    rst = 1'b0; #1;
    chk("mr_req3", 32'(imem_req), 32'd1);
    tick(); #1;
    chk("mr_valid4", 32'(IFID_valid), 32'd1);
    chk("mr_ifpc4",  IFID_PC,         32'h8000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
